// File: rtl/aes_pkg.sv
// Shared AES-128 constants: sizes, round-constant table, S-box ROM and GF(2^8) xtime.
package aes_pkg;

  localparam int Nb = 4;
  localparam int Nk = 4;
  localparam int Nr = 10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ks_state_t;

  localparam logic [7:0] RCON [0:9] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Combinational SubWord: four parallel S-box byte lookups on a 32-bit word.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] word,
  output logic [31:0] sub
);

  assign sub = {SBOX[word[31:24]], SBOX[word[23:16]], SBOX[word[15:8]], SBOX[word[7:0]]};

endmodule

// File: rtl/aes_key_scheduler.sv
// Iterative AES-128 key expansion streaming round keys 0..Nr over a valid/ready handshake.
// state | meaning
// IDLE  | no schedule active; start accepted unless done is still pulsing
// RUN   | round_key/rk_index presented, advancing one key per handshake
module aes_key_scheduler #(
  parameter int N  = 128,
  parameter int Nr = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] key_in,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [N-1:0] round_key,
  output logic [3:0]   rk_index,
  output logic         busy,
  output logic         done
);
  import aes_pkg::*;

  if (N != 32 * Nb || N != 32 * Nk || Nr != aes_pkg::Nr) begin : g_param_check
    $error("aes_key_scheduler supports only N=128, Nr=10");
  end

  localparam logic [3:0] LAST_IDX = 4'(Nr);

  ks_state_t      state, state_d;
  logic [7:0]     rcon, rcon_d;
  logic [N-1:0]   key_d;
  logic [3:0]     idx_d;
  logic           valid_d, busy_d, done_d;

  logic [31:0] w0, w1, w2, w3, rot_w3, sub_rot, t;
  logic [31:0] n0, n1, n2, n3;
  logic [N-1:0] next_key;

  assign {w0, w1, w2, w3} = round_key;
  assign rot_w3 = {w3[23:0], w3[31:24]};

  aes_sub_word u_sub_word (
    .word (rot_w3),
    .sub  (sub_rot)
  );

  assign t  = sub_rot ^ {rcon, 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  always_comb begin
    state_d = state;
    key_d   = round_key;
    idx_d   = rk_index;
    rcon_d  = rcon;
    valid_d = rk_valid;
    busy_d  = busy;
    done_d  = 1'b0;
    case (state)
      IDLE: begin
        // done still high means the final handshake just happened; hold off a restart one cycle
        if (start && !done) begin
          state_d = RUN;
          key_d   = key_in;
          idx_d   = 4'd0;
          rcon_d  = RCON[0];
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        if (rk_valid && rk_ready) begin
          if (rk_index == LAST_IDX) begin
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            key_d  = next_key;
            idx_d  = rk_index + 4'd1;
            rcon_d = xtime(rcon);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      round_key <= '0;
      rk_index  <= 4'd0;
      rcon      <= RCON[0];
      rk_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      round_key <= key_d;
      rk_index  <= idx_d;
      rcon      <= rcon_d;
      rk_valid  <= valid_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_aes_key_scheduler.sv
// Directed bench for aes_key_scheduler using FIPS-197 key-expansion vectors.
module tb_aes_key_scheduler;

  localparam logic [127:0] KEY_A    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_B    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY_B_10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] key;
  } vec_t;

  logic         clk;
  logic         reset;
  logic         start;
  logic [127:0] key_in;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] round_key;
  logic [3:0]   rk_index;
  logic         busy;
  logic         done;

  int   n_vec = 0;
  int   n_err = 0;
  vec_t tbl [11];

  aes_key_scheduler #(.N(128), .Nr(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .key_in    (key_in),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .round_key (round_key),
    .rk_index  (rk_index),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start_sched(input logic [127:0] k);
    @(negedge clk);
    key_in = k;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Walks KEY_A's 11 round keys; stall applies a 1,0,0 ready pattern, poke fires start with KEY_B mid-run.
  task automatic run_tbl(input bit stall, input bit poke);
    int i   = 0;
    int cyc = 0;
    while (i <= 10 && cyc < 200) begin
      chk("valid",      128'(rk_valid), 128'(1));
      chk("index",      128'(rk_index), 128'(tbl[i].idx));
      chk("round_key",  round_key,      tbl[i].key);
      chk("busy",       128'(busy),     128'(1));
      chk("done_early", 128'(done),     128'(0));
      rk_ready = stall ? 1'((cyc % 3) == 0) : 1'b1;
      if (poke) begin
        start  = (i >= 3 && i <= 5);
        key_in = KEY_B;
      end
      if (rk_ready) i++;
      cyc++;
      @(negedge clk);
    end
    if (poke) start = 1'b0;
    chk("handshakes",  128'(i),        128'(11));
    chk("done_pulse",  128'(done),     128'(1));
    chk("done_valid",  128'(rk_valid), 128'(0));
    chk("done_busy",   128'(busy),     128'(0));
  endtask

  task automatic run_to_last();
    int c = 0;
    while (rk_index != 4'd10 && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("last_index", 128'(rk_index), 128'(10));
  endtask

  initial begin
    tbl[0]  = '{4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
    tbl[1]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
    tbl[2]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
    tbl[3]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
    tbl[4]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
    tbl[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
    tbl[6]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
    tbl[7]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
    tbl[8]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
    tbl[9]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
    tbl[10] = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

    reset    = 1'b0;
    start    = 1'b0;
    key_in   = '0;
    rk_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 128'(rk_valid), 128'(0));
    chk("rst_busy",  128'(busy),     128'(0));
    chk("rst_done",  128'(done),     128'(0));
    chk("rst_index", 128'(rk_index), 128'(0));
    chk("rst_key",   round_key,      128'(0));
    reset = 1'b1;

    // straight run at full throughput
    rk_ready = 1'b1;
    start_sched(KEY_A);
    run_tbl(1'b0, 1'b0);
    @(negedge clk);
    chk("done_width", 128'(done),     128'(0));
    chk("idle_valid", 128'(rk_valid), 128'(0));

    // stalled run
    start_sched(KEY_A);
    run_tbl(1'b1, 1'b0);
    @(negedge clk);
    chk("stall_done_width", 128'(done), 128'(0));

    // start poked mid-run must not disturb the schedule
    rk_ready = 1'b1;
    start_sched(KEY_A);
    run_tbl(1'b0, 1'b1);
    @(negedge clk);

    // start held across done: one idle cycle, then a new schedule with the current key_in
    key_in = KEY_A;
    start  = 1'b1;
    @(negedge clk);
    key_in = KEY_B;
    run_tbl(1'b0, 1'b0);
    @(negedge clk);
    chk("gap_valid", 128'(rk_valid), 128'(0));
    chk("gap_done",  128'(done),     128'(0));
    chk("gap_busy",  128'(busy),     128'(0));
    @(negedge clk);
    start = 1'b0;
    chk("restart_valid", 128'(rk_valid), 128'(1));
    chk("restart_index", 128'(rk_index), 128'(0));
    chk("restart_key",   round_key,      KEY_B);
    run_to_last();
    chk("restart_key10", round_key, KEY_B_10);
    @(negedge clk);
    chk("restart_done", 128'(done), 128'(1));

    // asynchronous reset at rk_index 5
    start_sched(KEY_A);
    begin
      int c = 0;
      while (rk_index != 4'd5 && c < 50) begin
        @(negedge clk);
        c++;
      end
    end
    chk("pre_reset_index", 128'(rk_index), 128'(5));
    #2 reset = 1'b0;
    #1;
    chk("async_valid", 128'(rk_valid), 128'(0));
    chk("async_busy",  128'(busy),     128'(0));
    chk("async_index", 128'(rk_index), 128'(0));
    chk("async_key",   round_key,      128'(0));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("reset_no_done", 128'(done), 128'(0));
    end
    reset = 1'b1;
    @(negedge clk);
    chk("post_reset_done", 128'(done), 128'(0));
    start_sched(KEY_B);
    chk("b_key0", round_key, KEY_B);
    run_to_last();
    chk("b_key10", round_key, KEY_B_10);
    @(negedge clk);
    chk("b_done",  128'(done),     128'(1));
    chk("b_valid", 128'(rk_valid), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
